// File: rtl/decodificador_acesso_seq.sv
// Sequential user/function access decoder: valid/ready request, permission table lookup,
// timed one-hot grant display and lockout after consecutive denials.
// Optional audit counters are enabled with the macro DECOD_ACESSO_AUDIT_EN.
module decodificador_acesso_seq #(
    parameter int          USER_W      = 3,
    parameter int          FUNC_W      = 3,
    parameter logic [63:0] PERM        = 64'h0042_FE00_5E00_5A00,
    parameter logic [7:0]  LED_SEL     = 8'h42,
    parameter int          HOLD_CYCLES = 16,
    parameter int          MAX_FAILS   = 3,
    parameter int          LOCK_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef DECOD_ACESSO_AUDIT_EN
    input  logic                     i_audit_clr,
    output logic [7:0]               o_grant_cnt,
    output logic [7:0]               o_deny_cnt,
`endif
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [USER_W-1:0]        i_user,
    input  logic [FUNC_W-1:0]        i_func,
    output logic [(1<<FUNC_W)-2:0]   o_matrix_col,
    output logic [(1<<FUNC_W)-2:0]   o_led,
    output logic                     o_grant,
    output logic                     o_deny,
    output logic                     o_locked
);
    localparam int NF     = 1 << FUNC_W;
    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam int LOCK_W = $clog2(LOCK_CYCLES) + 1;
    localparam int FAIL_W = $clog2(MAX_FAILS) + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_GRANT = 3'd2,
        ST_DENY  = 3'd3,
        ST_LOCK  = 3'd4
    } state_t;

    state_t              r_state, w_state_n;
    logic                r_pend, w_pend_n;
    logic [USER_W-1:0]   r_user, w_user_n;
    logic [FUNC_W-1:0]   r_func, w_func_n;
    logic [HOLD_W-1:0]   r_hold, w_hold_n;
    logic [LOCK_W-1:0]   r_lock, w_lock_n;
    logic [FAIL_W-1:0]   r_fail, w_fail_n;
    logic [NF-2:0]       r_matrix, w_matrix_n;
    logic [NF-2:0]       r_led, w_led_n;
    logic                r_grant, w_grant_n;
    logic                r_deny, w_deny_n;
    logic                r_locked, w_locked_n;
    logic                w_ok;
    logic                w_ready;
    logic [NF-2:0]       w_onehot;

    // {user, func} is exactly user*NF + func, the table bit index
    assign w_ok     = (r_func != FUNC_W'(0)) && PERM[{r_user, r_func}];
    assign w_onehot = (NF-1)'(1) << (r_func - FUNC_W'(1));
    // The accepted request is held one cycle in IDLE (r_pend) before CHECK
    assign w_ready  = (r_state == ST_IDLE) && !r_pend;

    assign o_req_ready  = rst_n & w_ready;
    assign o_matrix_col = r_matrix;
    assign o_led        = r_led;
    assign o_grant      = r_grant;
    assign o_deny       = r_deny;
    assign o_locked     = r_locked;

    // Next-state and registered-output logic
    always_comb begin
        w_state_n  = r_state;
        w_pend_n   = r_pend;
        w_user_n   = r_user;
        w_func_n   = r_func;
        w_hold_n   = r_hold;
        w_lock_n   = r_lock;
        w_fail_n   = r_fail;
        w_matrix_n = r_matrix;
        w_led_n    = r_led;
        w_grant_n  = r_grant;
        w_deny_n   = r_deny;
        w_locked_n = r_locked;
        case (r_state)
            ST_IDLE: begin
                if (r_pend) begin
                    w_pend_n  = 1'b0;
                    w_state_n = ST_CHECK;
                end else if (i_req_valid) begin
                    w_pend_n = 1'b1;
                    w_user_n = i_user;
                    w_func_n = i_func;
                end else begin
                    w_pend_n = 1'b0;
                end
            end
            ST_CHECK: begin
                if (w_ok) begin
                    w_state_n = ST_GRANT;
                    w_grant_n = 1'b1;
                    w_hold_n  = HOLD_W'(HOLD_CYCLES);
                    w_fail_n  = FAIL_W'(0);
                    if (LED_SEL[r_user]) begin
                        w_led_n = w_onehot;
                    end else begin
                        w_matrix_n = w_onehot;
                    end
                end else begin
                    w_state_n = ST_DENY;
                    w_deny_n  = 1'b1;
                    if (r_fail < FAIL_W'(MAX_FAILS)) begin
                        w_fail_n = r_fail + FAIL_W'(1);
                    end else begin
                        w_fail_n = r_fail;
                    end
                end
            end
            ST_GRANT: begin
                if (r_hold <= HOLD_W'(1)) begin
                    w_state_n  = ST_IDLE;
                    w_hold_n   = HOLD_W'(0);
                    w_grant_n  = 1'b0;
                    w_matrix_n = '0;
                    w_led_n    = '0;
                end else begin
                    w_hold_n = r_hold - HOLD_W'(1);
                end
            end
            ST_DENY: begin
                w_deny_n = 1'b0;
                if (r_fail == FAIL_W'(MAX_FAILS)) begin
                    w_state_n  = ST_LOCK;
                    w_locked_n = 1'b1;
                    w_lock_n   = LOCK_W'(LOCK_CYCLES);
                end else begin
                    w_state_n = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (r_lock <= LOCK_W'(1)) begin
                    w_state_n  = ST_IDLE;
                    w_lock_n   = LOCK_W'(0);
                    w_locked_n = 1'b0;
                    w_fail_n   = FAIL_W'(0);
                end else begin
                    w_lock_n = r_lock - LOCK_W'(1);
                end
            end
            default: begin
                w_state_n  = ST_IDLE;
                w_pend_n   = 1'b0;
                w_hold_n   = HOLD_W'(0);
                w_lock_n   = LOCK_W'(0);
                w_fail_n   = FAIL_W'(0);
                w_matrix_n = '0;
                w_led_n    = '0;
                w_grant_n  = 1'b0;
                w_deny_n   = 1'b0;
                w_locked_n = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_pend   <= 1'b0;
            r_user   <= '0;
            r_func   <= '0;
            r_hold   <= '0;
            r_lock   <= '0;
            r_fail   <= '0;
            r_matrix <= '0;
            r_led    <= '0;
            r_grant  <= 1'b0;
            r_deny   <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_pend   <= w_pend_n;
            r_user   <= w_user_n;
            r_func   <= w_func_n;
            r_hold   <= w_hold_n;
            r_lock   <= w_lock_n;
            r_fail   <= w_fail_n;
            r_matrix <= w_matrix_n;
            r_led    <= w_led_n;
            r_grant  <= w_grant_n;
            r_deny   <= w_deny_n;
            r_locked <= w_locked_n;
        end
    end

`ifdef DECOD_ACESSO_AUDIT_EN
    logic [7:0] r_grant_cnt;
    logic [7:0] r_deny_cnt;
    logic       w_chk;

    assign w_chk       = (r_state == ST_CHECK);
    assign o_grant_cnt = r_grant_cnt;
    assign o_deny_cnt  = r_deny_cnt;

    // Saturating audit counters; a clear in the same cycle as an event wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_cnt <= 8'd0;
            r_deny_cnt  <= 8'd0;
        end else if (i_audit_clr) begin
            r_grant_cnt <= 8'd0;
            r_deny_cnt  <= 8'd0;
        end else begin
            if (w_chk && w_ok && (r_grant_cnt != 8'hFF)) begin
                r_grant_cnt <= r_grant_cnt + 8'd1;
            end
            if (w_chk && !w_ok && (r_deny_cnt != 8'hFF)) begin
                r_deny_cnt <= r_deny_cnt + 8'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_decodificador_acesso_seq.sv
// Self-checking bench for decodificador_acesso_seq: directed test-plan steps followed by
// random requests, each checked cycle by cycle against a timeline model of the access rules.
module tb_decodificador_acesso_seq;
    localparam logic [63:0] PERM  = 64'h0042_FE00_5E00_5A00;
    localparam logic [7:0]  LSEL  = 8'h42;
    localparam int          HOLD  = 16;
    localparam int          MAXF  = 3;
    localparam int          LOCKC = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_req_valid;
    logic       o_req_ready;
    logic [2:0] i_user;
    logic [2:0] i_func;
    logic [6:0] o_matrix_col;
    logic [6:0] o_led;
    logic       o_grant;
    logic       o_deny;
    logic       o_locked;
`ifdef DECOD_ACESSO_AUDIT_EN
    logic       i_audit_clr;
    logic [7:0] o_grant_cnt;
    logic [7:0] o_deny_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int m_fails  = 0;
    int m_grants = 0;
    int m_denies = 0;
    logic [63:0] perm_v = PERM;
    logic [7:0]  lsel_v = LSEL;

    always #5 clk = ~clk;

    decodificador_acesso_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef DECOD_ACESSO_AUDIT_EN
        .i_audit_clr  (i_audit_clr),
        .o_grant_cnt  (o_grant_cnt),
        .o_deny_cnt   (o_deny_cnt),
`endif
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_user       (i_user),
        .i_func       (i_func),
        .o_matrix_col (o_matrix_col),
        .o_led        (o_led),
        .o_grant      (o_grant),
        .o_deny       (o_deny),
        .o_locked     (o_locked)
    );

    function automatic logic [17:0] exp_v(logic rdy, logic g, logic d, logic l,
                                          logic [6:0] m, logic [6:0] ld);
        return {rdy, g, d, l, m, ld};
    endfunction

    function automatic logic [17:0] obs_v();
        return {o_req_ready, o_grant, o_deny, o_locked, o_matrix_col, o_led};
    endfunction

    task automatic chk(input string tag, input logic [17:0] e);
        checks++;
        assert (obs_v() === e) else begin
            failures++;
            $error("FAIL %s observed={rdy,g,d,l,mat,led}=%h expected=%h", tag, obs_v(), e);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] o, input int e);
        checks++;
        assert (o === 8'(e)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // One request from an IDLE negedge; checks every cycle until IDLE again.
    task automatic request(input int u, input int f, input string tag);
        logic       ok;
        logic [6:0] oh;
        logic       to_led;
        ok     = (f != 0) && perm_v[u*8 + f];
        oh     = 7'd0;
        if (f != 0) oh[f-1] = 1'b1;
        to_led = lsel_v[u];
        chk({tag, ":idle"}, exp_v(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0));
        i_req_valid = 1'b1;
        i_user      = 3'(u);
        i_func      = 3'(f);
        @(negedge clk);
        i_req_valid = 1'b0;
        i_user      = 3'($urandom);
        i_func      = 3'($urandom);
        chk({tag, ":acc"}, exp_v(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0));
        @(negedge clk);
        chk({tag, ":chk"}, exp_v(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0));
        @(negedge clk);
        if (ok) begin
            m_fails = 0;
            m_grants++;
            for (int i = 0; i < HOLD; i++) begin
                chk({tag, ":hold"}, exp_v(1'b0, 1'b1, 1'b0, 1'b0,
                                          to_led ? 7'd0 : oh, to_led ? oh : 7'd0));
                @(negedge clk);
            end
        end else begin
            m_denies++;
            if (m_fails < MAXF) m_fails++;
            chk({tag, ":deny"}, exp_v(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0));
            @(negedge clk);
            if (m_fails == MAXF) begin
                for (int i = 0; i < LOCKC; i++) begin
                    chk({tag, ":lock"}, exp_v(1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 7'd0));
                    if (i == 5) begin
                        i_req_valid = 1'b1;
                        i_user      = 3'd5;
                        i_func      = 3'd7;
                    end
                    if (i == 9) i_req_valid = 1'b0;
                    @(negedge clk);
                end
                m_fails = 0;
            end
        end
        chk({tag, ":back"}, exp_v(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0));
    endtask

    initial begin
        rst_n       = 1'b0;
        i_req_valid = 1'b0;
        i_user      = 3'd0;
        i_func      = 3'd0;
`ifdef DECOD_ACESSO_AUDIT_EN
        i_audit_clr = 1'b0;
`endif
        #1;
        chk("reset", exp_v(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel", exp_v(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0));

        request(5, 7, "u5f7");
        request(1, 4, "u1f4");
        request(6, 6, "u6f6");
        request(3, 5, "u3f5");
        request(1, 4, "clr");
        request(0, 1, "d1");
        request(0, 1, "d2");
        request(0, 1, "d3");
        request(5, 1, "postlock");
        request(0, 1, "nd1");
        request(3, 5, "nd2");
        request(5, 7, "ng");
        request(0, 1, "nd3");
        request(5, 0, "nd4");
        request(1, 4, "ng2");

        // Reset in the middle of a grant
        i_req_valid = 1'b1;
        i_user      = 3'd5;
        i_func      = 3'd7;
        @(negedge clk);
        i_req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst", exp_v(1'b0, 1'b1, 1'b0, 1'b0, 7'b1000000, 7'd0));
        rst_n = 1'b0;
        #1;
        chk("mid_rst", exp_v(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0));
        m_fails  = 0;
        m_grants = 0;
        m_denies = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rel", exp_v(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0));
        request(6, 6, "after_rst");

        for (int n = 0; n < 30; n++) begin
            request(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), "rnd");
        end

`ifdef DECOD_ACESSO_AUDIT_EN
        chk8("grant_cnt", o_grant_cnt, m_grants);
        chk8("deny_cnt", o_deny_cnt, m_denies);
        i_audit_clr = 1'b1;
        @(negedge clk);
        i_audit_clr = 1'b0;
        chk8("grant_clr", o_grant_cnt, 0);
        chk8("deny_clr", o_deny_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
